// File: rtl/bcd_xs3_sequencer.sv
// Multi-digit BCD to excess-3 converter that reuses one 4-bit code converter.
// Optional macro BCD_CHECK_EN adds invalid-nibble detection (err, 4'hF slot).

// 4-bit BCD to excess-3 digit converter (a/x = MSB, out = digit + 3).
module code_converter (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic x,
    output logic y,
    output logic z,
    output logic w
);

    // Minimised sum terms; inputs 10-15 fall in the don't-care region.
    assign w = ~d;
    assign z = c ~^ d;
    assign y = b ^ (c | d);
    assign x = a | (b & (c | d));

endmodule

module bcd_xs3_sequencer #(
    parameter int DIGITS = 4,
    parameter int IDX_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   xs3_out,
    output logic                  err,
    output logic [IDX_W-1:0]      digit_idx
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [1:0]          state;
    logic [4*DIGITS-1:0] operand;
    logic [3:0]          nib;
    logic [3:0]          conv;
    logic [3:0]          slot;
    logic                last;

    assign busy = (state == CONV);
    assign done = (state == DONE);
    assign last = (digit_idx == LAST_IDX);

    code_converter u_conv (
        .a (nib[3]),
        .b (nib[2]),
        .c (nib[1]),
        .d (nib[0]),
        .x (conv[3]),
        .y (conv[2]),
        .z (conv[1]),
        .w (conv[0])
    );

`ifdef BCD_CHECK_EN
    logic bad;

    // Select the active operand nibble and mark invalid digits with 4'hF.
    always_comb begin
        nib  = operand[{digit_idx, 2'b00} +: 4];
        bad  = (nib > 4'd9);
        slot = bad ? 4'hF : conv;
    end

    // Sticky error flag, cleared when a new job is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == IDLE && start) begin
            err <= 1'b0;
        end else if (state == CONV && bad) begin
            err <= 1'b1;
        end
    end
`else
    // Select the active operand nibble; converter output is used as-is.
    always_comb begin
        nib  = operand[{digit_idx, 2'b00} +: 4];
        slot = conv;
    end

    assign err = 1'b0;
`endif

    // Control FSM: latch operand, walk one nibble per clock, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            operand   <= '0;
            xs3_out   <= '0;
            digit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        operand   <= bcd_in;
                        xs3_out   <= '0;
                        digit_idx <= '0;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    xs3_out[{digit_idx, 2'b00} +: 4] <= slot;
                    if (last) begin
                        digit_idx <= '0;
                        state     <= DONE;
                    end else begin
                        digit_idx <= digit_idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    digit_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_xs3_sequencer.sv
// Directed bench for bcd_xs3_sequencer with a result scoreboard.
// Invalid-digit steps are built only when BCD_CHECK_EN is defined.
module tb_bcd_xs3_sequencer;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] bcd_in;
    logic         busy;
    logic         done;
    logic [W-1:0] xs3_out;
    logic         err;
    logic [1:0]   digit_idx;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W:0] sb[$];

    bcd_xs3_sequencer #(.DIGITS(D), .IDX_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .xs3_out   (xs3_out),
        .err       (err),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: {err, result}.
    function automatic logic [W:0] model(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         e;
        logic [3:0]   n;
        r = '0;
        e = 1'b0;
        for (int i = 0; i < D; i++) begin
            n = v[4*i +: 4];
`ifdef BCD_CHECK_EN
            if (n > 4'd9) begin
                e = 1'b1;
                r[4*i +: 4] = 4'hF;
            end else begin
                r[4*i +: 4] = n + 4'd3;
            end
`else
            r[4*i +: 4] = n + 4'd3;
`endif
        end
        return {e, r};
    endfunction

    // inject: busy cycle to raise a spurious start (-1 none)
    // rst_at: busy cycle to assert reset (-1 none)
    task automatic run_job(input logic [W-1:0] data, input int inject,
                           input int rst_at);
        logic [W:0] exp;
        @(negedge clk);
        bcd_in = data;
        start  = 1'b1;
        sb.push_back(model(data));
        @(negedge clk);
        start  = 1'b0;
        bcd_in = W'($urandom);
        for (int i = 0; i < D; i++) begin
            check("busy", 32'(busy), 1);
            check("done_in_conv", 32'(done), 0);
            check("idx", 32'(digit_idx), i);
            check("unwritten_zero", 32'(xs3_out >> (4 * i)), 0);
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                void'(sb.pop_back());
                check("rst_busy", 32'(busy), 0);
                check("rst_done", 32'(done), 0);
                check("rst_xs3", 32'(xs3_out), 0);
                check("rst_idx", 32'(digit_idx), 0);
                check("rst_err", 32'(err), 0);
                for (int j = 0; j < D + 2; j++) begin
                    @(negedge clk);
                    check("rst_no_done", 32'(done), 0);
                    check("rst_idle", 32'(busy), 0);
                end
                return;
            end
            if (i == inject) begin
                start  = 1'b1;
                bcd_in = 16'h1111;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_idx", 32'(digit_idx), 0);
        check("sb_size", 32'(sb.size()), 1);
        exp = sb.pop_front();
        check("result", 32'(xs3_out), 32'(exp[W-1:0]));
        check("err", 32'(err), 32'(exp[W]));
        @(negedge clk);
        check("done_once", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("hold_result", 32'(xs3_out), 32'(exp[W-1:0]));
        check("hold_err", 32'(err), 32'(exp[W]));
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        bcd_in = 16'h5555;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_xs3", 32'(xs3_out), 0);
        check("reset_err", 32'(err), 0);
        check("reset_idx", 32'(digit_idx), 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(busy), 0);

        run_job(16'h1234, -1, -1);
        run_job(16'h9090, -1, -1);
        run_job(16'h0000, -1, -1);
        run_job(16'h9999, -1, -1);
`ifdef BCD_CHECK_EN
        run_job(16'h12A4, -1, -1);
        check("invalid_val", 32'(xs3_out), 32'h45F7);
        check("invalid_err", 32'(err), 1);
        run_job(16'h0001, -1, -1);
        check("err_cleared", 32'(err), 0);
        check("after_invalid", 32'(xs3_out), 32'h3334);
`endif
        run_job(16'h5678, 1, -1);
        check("ignored_start", 32'(xs3_out), 32'h89AB);
        run_job(16'h4321, -1, 2);
        run_job(16'h2468, -1, -1);
        check("after_rst_job", 32'(xs3_out), 32'h579B);
        check("sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_xs3_sequencer.md
Name: bcd_xs3_sequencer

Overview:
- Multi-digit BCD-to-excess-3 conversion controller.
- Time-shares one instance of the team's 4-bit combinational `code_converter` (inputs a,b,c,d; outputs x,y,z,w; a/x = MSB; output = digit+3 for digits 0–9) across a packed word of DIGITS BCD nibbles, one nibble per clock.
- Provides a start/busy/done handshake so lab top-levels (switch/LED or 7-segment boards) can convert a whole multi-digit number with a single command.

Parameters:
- DIGITS, 4, number of BCD nibbles per word (legal range 2–8).
- IDX_W, 2, width of digit index; must satisfy 2**IDX_W >= DIGITS.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD word; nibble 0 = bits [3:0] = least-significant digit.
- busy  output  1  high while the conversion is in progress (CONV state).
- done  output  1  one-cycle pulse; xs3_out is complete and valid.
- xs3_out  output  4*DIGITS  packed excess-3 result, same nibble order as bcd_in.
- err  output  1  sticky per job; set if any input nibble > 9.
- digit_idx  output  IDX_W  nibble currently being converted; 0 outside CONV.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). rst has priority over every other event, including mid-conversion.
- Reset values: state=IDLE, busy=0, done=0, xs3_out=0, err=0, digit_idx=0, internal operand register=0.
- FSM states: IDLE, CONV, DONE. All outputs are registered or decoded directly from state.
- IDLE:
  - start=1 at edge k → latch bcd_in into the operand register, clear xs3_out and err, set digit_idx=0, go to CONV.
  - start=0 → stay in IDLE; xs3_out and err hold the previous job's values.
- CONV:
  - busy=1.
  - Each edge: operand nibble[digit_idx] drives a,b,c,d of the converter; the converter output x,y,z,w is written into xs3_out nibble[digit_idx]; digit_idx increments.
  - When digit_idx == DIGITS-1 at an edge, write the last nibble, reset digit_idx to 0 and go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then unconditional return to IDLE.
- Latency: start accepted at edge k → CONV writes occur on edges k+1 … k+DIGITS → done is high during the cycle following edge k+DIGITS. Total = DIGITS+1 cycles; next job can be accepted at edge k+DIGITS+2.
- start while in CONV or DONE is ignored; it is not queued.
- bcd_in changes after the accepting edge have no effect, because the operand is latched.
- xs3_out nibbles not yet written in the current job read 0 while busy.
- Each nibble is 4 bits wide; the converter's result is taken as-is, with no carry between digits.
- rst asserted mid-CONV: next edge forces IDLE and all reset values; the partial result is discarded and no done pulse is produced.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - During CONV, a nibble > 9 sets err (sticky until the next accepted start).
  - That nibble's xs3_out slot is forced to 4'hF instead of the converter output.
  - Valid nibbles are unaffected.
- Undefined:
  - err is tied 0.
  - Nibbles 10–15 pass through the converter unchanged; the result for those inputs is unspecified (converter don't-care region).
  - No extra logic is present.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 → busy=0, done=0, xs3_out=0, err=0, digit_idx=0; no conversion begins.
- Basic (DIGITS=4): bcd_in=16'h1234, pulse start for 1 cycle → busy=1 for 4 cycles, digit_idx steps 0,1,2,3, done=1 for one cycle on the 5th cycle, xs3_out=16'h4567, err=0; xs3_out still 16'h4567 in IDLE afterwards.
- Boundary digits: bcd_in=16'h9090 → xs3_out=16'hC3C3; bcd_in=16'h0000 → 16'h3333; bcd_in=16'h9999 → 16'hCCCC.
- Invalid digit (BCD_CHECK_EN defined): bcd_in=16'h12A4 → xs3_out=16'h45F7, err=1; next start with 16'h0001 → err clears on accept, result 16'h3334.
- Start during busy: start job 16'h5678; assert start again with bcd_in=16'h1111 on the 2nd busy cycle → ignored; exactly one done pulse, xs3_out=16'h89AB.
- Reset mid-operation: assert rst on the 3rd CONV cycle → next edge busy=0, xs3_out=0, state IDLE, no done pulse; a new start afterwards completes normally.
